// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the ARM-subset pipeline: instruction encodings,
// field positions, fetch FSM encoding and the IF/ID register layout.
package fetch_stage_pkg;

    localparam int PC_W = 32;
    localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;  // MOV R0,R0

    // Fetch FSM encoding
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    // Instruction field positions
    localparam int CLASS_HI = 27;
    localparam int CLASS_LO = 25;
    localparam int L_BIT    = 24;
    localparam int OFF_HI   = 23;
    localparam int OFF_LO   = 0;
    localparam int OFF_W    = OFF_HI - OFF_LO + 1;

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic            valid;
    } if_id_t;

    // Word offset -> signed byte offset
    function automatic logic [PC_W-1:0] sext_word_offset(input logic [OFF_W-1:0] off);
        return {{(PC_W-OFF_W-2){off[OFF_W-1]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_branch_target_calc.sv
// B/BL target and BL link address derived from the instruction held in IF/ID.
module branch_target_calc
    import fetch_stage_pkg::*;
(
    input  logic [PC_W-1:0]  if_id_pc,
    input  logic [OFF_W-1:0] offset24,
    output logic [PC_W-1:0]  branch_target,
    output logic [PC_W-1:0]  link_addr
);

    // ARM PC reads two words ahead of the executing instruction
    assign branch_target = if_id_pc + PC_W'(8) + sext_word_offset(offset24);
    assign link_addr     = if_id_pc + PC_W'(4);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, instruction-memory drive, IF/ID register,
// stall hold, taken-branch redirect and halt on running off the end of memory.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter int          MEM_BYTES = 256,
    parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic [31:0] branch_target,
    output logic [31:0] link_addr,
    output logic        halted
);

    logic [0:0]  state;
    logic [31:0] pc_q;
    if_id_t      if_id;
    logic        pc_in_mem;
    logic        redirect;

    assign pc_in_mem = pc_q < 32'(MEM_BYTES);
    assign redirect  = branch_taken & if_id.valid & ~stall;

    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign imem_en     = (state == ST_RUN) && pc_in_mem;
    assign if_id_instr = if_id.instr;
    assign if_id_pc    = if_id.pc;
    assign if_id_valid = if_id.valid;
    assign halted      = (state == ST_HALT);

    branch_target_calc u_btc (
        .if_id_pc      (if_id.pc),
        .offset24      (if_id.instr[OFF_HI:OFF_LO]),
        .branch_target (branch_target),
        .link_addr     (link_addr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            pc_q        <= PC_RESET;
            if_id.instr <= NOP_INSTR;
            if_id.pc    <= '0;
            if_id.valid <= 1'b0;
        end else if (state == ST_HALT) begin
            // Sticky until reset; keep feeding bubbles downstream
            if_id.instr <= NOP_INSTR;
            if_id.valid <= 1'b0;
        end else if (stall) begin
            // hold everything; decode re-asserts branch_taken after the stall
        end else if (redirect) begin
            // Squash the wrong-path fetch; an out-of-range target halts next edge
            pc_q        <= branch_target;
            if_id.instr <= NOP_INSTR;
            if_id.valid <= 1'b0;
        end else if (!pc_in_mem) begin
            state       <= ST_HALT;
            if_id.instr <= NOP_INSTR;
            if_id.valid <= 1'b0;
        end else begin
            if_id.instr <= imem_data;
            if_id.pc    <= pc_q;
            if_id.valid <= 1'b1;
            pc_q        <= pc_q + 32'd4;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: bench-side memory and reference model,
// expected IF/ID contents queued per edge and compared after the edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic [31:0] branch_target;
    logic [31:0] link_addr;
    logic        halted;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_valid   (if_id_valid),
        .branch_target (branch_target),
        .link_addr     (link_addr),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Big-endian byte memory
    logic [7:0] mem [256];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {mem[b], mem[b+8'd1], mem[b+8'd2], mem[b+8'd3]};
    endfunction

    always_comb begin
        imem_data = 32'h0;
        if (imem_addr < 32'd256) imem_data = word_at(imem_addr);
    end

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] idpc;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] pc;
        logic        halt;
    } exp_t;

    exp_t sb[$];
    exp_t m;  // bench model of the stage state

    task automatic model_reset();
        m.idpc = 32'h0; m.instr = NOP; m.valid = 1'b0; m.pc = 32'h0; m.halt = 1'b0;
    endtask

    // One clock edge with the given inputs; predicts, pushes, then pops and compares.
    task automatic cycle(input logic s, input logic b);
        exp_t e;
        exp_t g;
        logic [31:0] tgt;
        stall = s;
        branch_taken = b;
        #0;
        chk("imem_addr", imem_addr, m.pc);
        chk("imem_en", 32'(imem_en), 32'(!m.halt && m.pc < 32'd256));
        tgt = m.idpc + 32'd8 + {{6{m.instr[23]}}, m.instr[23:0], 2'b00};
        e = m;
        if (m.halt) begin
            e.instr = NOP; e.valid = 1'b0;
        end else if (s) begin
            e = m;
        end else if (b && m.valid) begin
            e.instr = NOP; e.valid = 1'b0; e.pc = tgt;
        end else if (m.pc >= 32'd256) begin
            e.instr = NOP; e.valid = 1'b0; e.halt = 1'b1;
        end else begin
            e.idpc = m.pc; e.instr = word_at(m.pc); e.valid = 1'b1; e.pc = m.pc + 32'd4;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("if_id_valid", 32'(if_id_valid), 32'(g.valid));
        chk("if_id_instr", if_id_instr, g.instr);
        if (g.valid) chk("if_id_pc", if_id_pc, g.idpc);
        chk("pc", pc, g.pc);
        chk("halted", 32'(halted), 32'(g.halt));
        chk("pc_align", 32'(pc[1:0]), 32'h0);
        m = g;
    endtask

    initial begin
        for (int i = 0; i < 256; i += 4) begin
            logic [31:0] w;
            w = 32'hE280_0000 | 32'(i);
            if (i == 16) w = 32'hEA00_0002;
            if (i == 32) w = 32'hEAFF_FFFE;
            mem[i] = w[31:24]; mem[i+1] = w[23:16]; mem[i+2] = w[15:8]; mem[i+3] = w[7:0];
        end

        // Reset wins over stall and branch_taken
        rst_n = 1'b0; stall = 1'b1; branch_taken = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", 32'(if_id_valid), 32'h0);
        chk("rst_instr", if_id_instr, NOP);
        chk("rst_halted", 32'(halted), 32'h0);
        model_reset();
        rst_n = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        #0;
        chk("rel_imem_addr", imem_addr, 32'h0);

        // Sequential fetch, with a 2-cycle stall at pc=8
        cycle(0, 0);
        chk("first_idpc", if_id_pc, 32'h0);
        chk("first_pc", pc, 32'h4);
        cycle(0, 0);
        cycle(1, 0);
        cycle(1, 1);
        chk("stall_pc", pc, 32'h8);
        chk("stall_idpc", if_id_pc, 32'h4);
        cycle(0, 0);
        chk("unstall_idpc", if_id_pc, 32'h8);
        cycle(0, 0);
        chk("seq_pc", pc, 32'h10);
        chk("seq_idpc", if_id_pc, 32'hC);

        // Forward branch EA000002 at 0x10
        cycle(0, 0);
        chk("bfwd_target", branch_target, 32'h20);
        chk("bfwd_link", link_addr, 32'h14);
        cycle(1, 1);
        chk("stall_br_pc", pc, 32'h14);
        chk("stall_br_valid", 32'(if_id_valid), 32'h1);
        cycle(0, 1);
        chk("redir_pc", pc, 32'h20);
        chk("redir_valid", 32'(if_id_valid), 32'h0);
        // branch_taken on a bubble is ignored
        cycle(0, 1);
        chk("tgt_idpc", if_id_pc, 32'h20);
        chk("self_target", branch_target, 32'h20);
        chk("self_link", link_addr, 32'h24);
        cycle(0, 1);
        chk("self_redir_pc", pc, 32'h20);
        cycle(0, 0);

        // Run to the end of memory
        begin
            int n;
            n = 0;
            while (m.pc != 32'd252 && n < 200) begin
                cycle(0, 0);
                n++;
            end
            chk("reach_252_in_budget", 32'(n < 200), 32'h1);
        end
        cycle(0, 0);
        chk("last_idpc", if_id_pc, 32'd252);
        chk("last_pc", pc, 32'd256);
        cycle(0, 0);
        chk("halt_enter", 32'(halted), 32'h1);
        chk("halt_imem_en", 32'(imem_en), 32'h0);
        for (int i = 0; i < 5; i++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk("halt_sustained", 32'(halted), 32'h1);
        chk("halt_valid", 32'(if_id_valid), 32'h0);

        // Reset exits HALT
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_halt_exit", 32'(halted), 32'h0);
        chk("rst_halt_pc", pc, 32'h0);
        chk("rst_halt_en", 32'(imem_en), 32'h1);
        model_reset();
        rst_n = 1'b1;
        cycle(0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
